// File: rtl/fetch_pkg.sv
// Shared types and defaults for the IF-stage fetch controller.
// ST_ERR exists only when FETCH_TIMEOUT_EN is defined.
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W  = 32;
   localparam int unsigned FETCH_DATA_W  = 32;
   localparam int unsigned FETCH_TIMEOUT = 64;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_DROP = 3'd4
`ifdef FETCH_TIMEOUT_EN
      , ST_ERR = 3'd5
`endif
   } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Response timeout counter for the fetch controller (FETCH_TIMEOUT_EN builds only).
// Counts consecutive waiting cycles and raises a sticky error on expiry.
module fetch_watchdog
   import fetch_pkg::*;
#(
   parameter int unsigned TIMEOUT = FETCH_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic rsp_i,
   output logic expire_o,
   output logic err_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // cnt_q holds the number of waiting cycles already elapsed, so the
   // TIMEOUT-th waiting cycle is the one that expires.
   always_comb begin
      expire_o = run_i && !rsp_i && (cnt_q == CNT_W'(TIMEOUT - 1));
      cnt_d    = '0;
      if (run_i && !rsp_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
      err_d = err_q || expire_o;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: one imem request per PC, PC stall / IF-ID flush generation,
// and discard of stale fetches after a redirect. Optional watchdog: FETCH_TIMEOUT_EN.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = FETCH_ADDR_W,
   parameter int unsigned DATA_W  = FETCH_DATA_W,
   parameter int unsigned TIMEOUT = FETCH_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_f,
   input  logic              pc_src_e,
   input  logic              hazard_stall_f,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              stall_f,
   output logic [DATA_W-1:0] instr_f,
   output logic              instr_valid_f,
   output logic              flush_d,
   output logic              fetch_err,
   output logic [2:0]        dbg_state_o
);

   // Request channel: a request transfers on a cycle with imem_req_valid && imem_req_ready;
   // once raised, valid and address stay stable until that cycle. Responses carry no
   // ready and arrive exactly once per transferred request, in order.

   fetch_state_e      state_q, state_d;
   logic              kill_q, kill_d;
   logic              req_held_q, req_held_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] hold_q, hold_d;

`ifdef FETCH_TIMEOUT_EN
   logic wd_run;
   logic wd_expire;

   assign wd_run = (state_q == ST_WAIT) || (state_q == ST_DROP);

   fetch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .run_i    (wd_run),
      .rsp_i    (imem_rsp_valid),
      .expire_o (wd_expire),
      .err_o    (fetch_err)
   );
`else
   assign fetch_err = 1'b0;
   if (TIMEOUT == 0) begin : g_timeout_unused
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_req_ready) begin
               state_d = (kill_q || pc_src_e) ? ST_DROP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               state_d = (hazard_stall_f && !pc_src_e) ? ST_HOLD : ST_REQ;
            end else if (pc_src_e) begin
               // the still-pending response belongs to the old path
               state_d = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (pc_src_e || !hazard_stall_f) begin
               state_d = ST_REQ;
            end
         end
         ST_DROP: begin
            if (imem_rsp_valid) begin
               state_d = ST_REQ;
            end
         end
`ifdef FETCH_TIMEOUT_EN
         ST_ERR: state_d = ST_ERR;
`endif
         default: state_d = ST_IDLE;
      endcase
`ifdef FETCH_TIMEOUT_EN
      if (wd_expire) begin
         state_d = ST_ERR;
      end
`endif
   end

   always_comb begin
      imem_req_valid = 1'b0;
      imem_req_addr  = '0;
      instr_valid_f  = 1'b0;
      instr_f        = '0;
      case (state_q)
         ST_REQ: begin
            imem_req_valid = 1'b1;
            imem_req_addr  = req_held_q ? addr_q : pc_f;
         end
         ST_WAIT: begin
            if (imem_rsp_valid && !pc_src_e && !hazard_stall_f) begin
               instr_valid_f = 1'b1;
               instr_f       = imem_rsp_data;
            end
         end
         ST_HOLD: begin
            instr_f       = hold_q;
            instr_valid_f = !pc_src_e && !hazard_stall_f;
         end
         default: ;
      endcase
      stall_f = !instr_valid_f && !pc_src_e;
`ifdef FETCH_TIMEOUT_EN
      if (state_q == ST_ERR) begin
         stall_f = 1'b1;
      end
`endif
      flush_d = pc_src_e;
   end

   // The first REQ cycle presents pc_f directly; later cycles replay the registered
   // copy because a redirect may already have moved pc_f.
   always_comb begin
      kill_d     = kill_q;
      req_held_d = 1'b0;
      addr_d     = addr_q;
      hold_d     = hold_q;
      if (state_q == ST_REQ) begin
         addr_d     = imem_req_addr;
         req_held_d = !imem_req_ready;
         kill_d     = imem_req_ready ? 1'b0 : (kill_q || pc_src_e);
      end
      if ((state_q == ST_WAIT) && imem_rsp_valid && hazard_stall_f && !pc_src_e) begin
         hold_d = imem_rsp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kill_q     <= 1'b0;
         req_held_q <= 1'b0;
         addr_q     <= '0;
         hold_q     <= '0;
      end else begin
         kill_q     <= kill_d;
         req_held_q <= req_held_d;
         addr_q     <= addr_d;
         hold_q     <= hold_d;
      end
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: PC register and instruction memory models around the DUT,
// a transaction-level reference model checked every cycle, and directed scenarios.
`timescale 1ns/1ps
module tb_fetch_controller;

   localparam int TO = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] pc_f;
   logic        pc_src_e;
   logic        hazard_stall_f;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        stall_f;
   logic [31:0] instr_f;
   logic        instr_valid_f;
   logic        flush_d;
   logic        fetch_err;
   logic [2:0]  dbg_state;

   fetch_controller #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_f           (pc_f),
      .pc_src_e       (pc_src_e),
      .hazard_stall_f (hazard_stall_f),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall_f        (stall_f),
      .instr_f        (instr_f),
      .instr_valid_f  (instr_valid_f),
      .flush_d        (flush_d),
      .fetch_err      (fetch_err),
      .dbg_state_o    (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // PC register of the pipeline
   logic [31:0] pc_q;
   logic [31:0] redirect_target;
   always @(posedge clk) begin
      if (rst) pc_q <= 32'h0;
      else if (pc_src_e) pc_q <= redirect_target;
      else if (!stall_f) pc_q <= pc_q + 32'd4;
   end
   assign pc_f = pc_q;

   // instruction memory
   bit          mem_busy = 0;
   bit          mem_mute = 0;
   int          mem_age  = 0;
   int          mem_lat  = 1;
   logic [31:0] mem_addr = 32'h0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h14) return 32'h00A00093;
      return 32'h1300_0000 | a;
   endfunction

   task automatic drive_mem();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (mem_busy && !mem_mute) begin
         mem_age++;
         if (mem_age >= mem_lat) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(mem_addr);
         end
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: request/response transactions, redirect epochs, hold buffer
   bit          m_on = 0, m_idle = 1, m_out = 0, m_pend = 0, m_err = 0, m_req_act = 0;
   int          m_epoch = 0, m_req_epoch = 0, m_wait = 0;
   logic [31:0] m_req_addr = 0, m_out_addr = 0, m_pend_word = 0;

   always @(negedge clk) begin
      logic        exp_req, stale, dlv;
      logic [31:0] exp_instr;
      exp_req   = m_on && !m_idle && !m_out && !m_pend && !m_err;
      stale     = (m_req_epoch != m_epoch) || pc_src_e;
      dlv       = 1'b0;
      exp_instr = 32'h0;
      if (!m_err) begin
         if (m_out && imem_rsp_valid) begin
            if (!stale && !hazard_stall_f) begin
               dlv       = 1'b1;
               exp_instr = word_at(m_out_addr);
            end
         end else if (m_pend) begin
            exp_instr = m_pend_word;
            dlv       = !pc_src_e && !hazard_stall_f;
         end
      end
      if (m_on) begin
         chk1("mon_req_valid", imem_req_valid, exp_req);
         if (exp_req) chk32("mon_req_addr", imem_req_addr, m_req_act ? m_req_addr : pc_f);
         chk1("mon_instr_valid", instr_valid_f, dlv);
         chk32("mon_instr", instr_f, exp_instr);
         chk1("mon_stall", stall_f, m_err || (!dlv && !pc_src_e));
         chk1("mon_flush", flush_d, pc_src_e);
         chk1("mon_err", fetch_err, m_err);
      end
      // memory bookkeeping
      if (rst) begin
         mem_busy = 0;
      end else begin
         if (imem_rsp_valid) mem_busy = 0;
         if (imem_req_valid && imem_req_ready) begin
            mem_busy = 1;
            mem_age  = 0;
            mem_addr = imem_req_addr;
         end
      end
      // model advance
      if (rst) begin
         m_on = 1; m_idle = 1; m_out = 0; m_pend = 0; m_err = 0; m_req_act = 0;
         m_epoch = 0; m_req_epoch = 0; m_wait = 0;
      end else if (m_on) begin
         m_idle = 0;
         if (m_out && imem_rsp_valid) begin
            m_out  = 0;
            m_wait = 0;
            if (!stale && hazard_stall_f) begin
               m_pend      = 1;
               m_pend_word = word_at(m_out_addr);
            end
         end else if (m_pend && (pc_src_e || !hazard_stall_f)) begin
            m_pend = 0;
         end else if (m_out) begin
            m_wait++;
`ifdef FETCH_TIMEOUT_EN
            if (m_wait == TO) m_err = 1;
`endif
         end
         if (exp_req) begin
            if (!m_req_act) begin
               m_req_addr  = pc_f;
               m_req_epoch = m_epoch;
            end
            if (imem_req_ready) begin
               m_out      = 1;
               m_out_addr = m_req_addr;
               m_req_act  = 0;
            end else begin
               m_req_act = 1;
            end
         end
         if (pc_src_e) m_epoch++;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      drive_mem();
   endtask

   task automatic cyc(input logic rdy, input logic src, input logic [31:0] tgt, input logic haz);
      tick();
      imem_req_ready  = rdy;
      pc_src_e        = src;
      redirect_target = tgt;
      hazard_stall_f  = haz;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; pc_src_e = 1'b0; hazard_stall_f = 1'b0; imem_req_ready = 1'b1;
      redirect_target = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      repeat (3) tick();
      @(negedge clk);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_stall", stall_f, 1'b1);
      chk1("rst_instr_valid", instr_valid_f, 1'b0);
      chk32("rst_instr", instr_f, 32'h0);
      chk1("rst_flush", flush_d, 1'b0);
      chk1("rst_err", fetch_err, 1'b0);

      tick(); rst = 1'b0; @(negedge clk);
      chk1("idle_req_valid", imem_req_valid, 1'b0);

      // zero-wait sequential fetch
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 0);
         chk1("zw_req_valid", imem_req_valid, 1'b1);
         chk32("zw_addr", imem_req_addr, 32'(4 * i));
         cyc(1, 0, 0, 0);
         chk1("zw_deliver", instr_valid_f, 1'b1);
         chk32("zw_instr", instr_f, 32'h1300_0000 | 32'(4 * i));
      end

      // backpressure
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0);
         chk1("bp_req_valid", imem_req_valid, 1'b1);
         chk32("bp_addr", imem_req_addr, 32'h10);
         chk1("bp_stall", stall_f, 1'b1);
      end
      cyc(1, 0, 0, 0);
      chk32("bp_accept_addr", imem_req_addr, 32'h10);
      cyc(1, 0, 0, 0);
      chk32("bp_instr", instr_f, 32'h1300_0010);

      // hazard stall on response
      cyc(1, 0, 0, 0);
      chk32("hz_addr", imem_req_addr, 32'h14);
      cyc(1, 0, 0, 1);
      chk1("hz_capture_valid", instr_valid_f, 1'b0);
      chk1("hz_capture_stall", stall_f, 1'b1);
      cyc(1, 0, 0, 1);
      chk1("hz_hold_valid", instr_valid_f, 1'b0);
      chk32("hz_hold_instr", instr_f, 32'h00A00093);
      cyc(1, 0, 0, 0);
      chk1("hz_release_valid", instr_valid_f, 1'b1);
      chk32("hz_release_instr", instr_f, 32'h00A00093);

      // redirect in WAIT, response one cycle later
      mem_lat = 2;
      cyc(1, 0, 0, 0);
      chk32("rw_addr", imem_req_addr, 32'h18);
      cyc(1, 1, 32'h40, 0);
      chk1("rw_flush", flush_d, 1'b1);
      chk1("rw_stall", stall_f, 1'b0);
      cyc(1, 0, 0, 0);
      chk1("rw_stale_dropped", instr_valid_f, 1'b0);
      chk1("rw_no_req", imem_req_valid, 1'b0);
      mem_lat = 1;

      // redirect coincident with handshake
      cyc(1, 1, 32'h80, 0);
      chk32("rh_target_40", imem_req_addr, 32'h40);
      chk1("rh_flush", flush_d, 1'b1);
      cyc(1, 0, 0, 0);
      chk1("rh_drop_valid", instr_valid_f, 1'b0);
      chk1("rh_drop_noreq", imem_req_valid, 1'b0);
      cyc(1, 0, 0, 0);
      chk32("rh_target_addr", imem_req_addr, 32'h80);
      cyc(1, 0, 0, 0);
      chk32("rh_instr", instr_f, 32'h1300_0080);

      // redirect while the request waits for ready
      cyc(0, 1, 32'h100, 0);
      chk32("kq_addr", imem_req_addr, 32'h84);
      cyc(1, 0, 0, 0);
      chk32("kq_addr_held", imem_req_addr, 32'h84);
      cyc(1, 0, 0, 0);
      chk1("kq_drop_valid", instr_valid_f, 1'b0);
      cyc(1, 0, 0, 0);
      chk32("kq_target_addr", imem_req_addr, 32'h100);
      cyc(1, 0, 0, 0);
      chk32("kq_instr", instr_f, 32'h1300_0100);

      // redirect while holding a captured response
      cyc(1, 0, 0, 0);
      chk32("hr_addr", imem_req_addr, 32'h104);
      cyc(1, 0, 0, 1);
      cyc(1, 1, 32'h200, 1);
      chk1("hr_valid", instr_valid_f, 1'b0);
      chk32("hr_instr", instr_f, 32'h1300_0104);
      cyc(1, 0, 0, 0);
      chk32("hr_target_addr", imem_req_addr, 32'h200);
      cyc(1, 0, 0, 0);
      chk32("hr_instr_target", instr_f, 32'h1300_0200);

`ifdef FETCH_TIMEOUT_EN
      // response timeout
      mem_mute = 1;
      cyc(1, 0, 0, 0);
      chk32("to_addr", imem_req_addr, 32'h204);
      for (int i = 0; i < TO; i++) begin
         cyc(1, 0, 0, 0);
         chk1("to_err_low", fetch_err, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0);
         chk1("to_err_set", fetch_err, 1'b1);
         chk1("to_no_req", imem_req_valid, 1'b0);
         chk1("to_stall", stall_f, 1'b1);
      end
      tick(); rst = 1'b1; mem_mute = 0; @(negedge clk);
      tick(); @(negedge clk);
      chk1("to_rst_clears", fetch_err, 1'b0);
      tick(); rst = 1'b0; @(negedge clk);
      cyc(1, 0, 0, 0);
      chk32("to_restart_addr", imem_req_addr, 32'h0);
      cyc(1, 0, 0, 0);
      chk32("to_restart_instr", instr_f, 32'h1300_0000);
`endif

      repeat (2) cyc(1, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
